alu_arb_seq: RTL and testbench

- Shares one W-bit ALU between two requesters (req0, req1) with round-robin arbitration.
- Each accepted request is sequenced through a 3-state controller: grant, execute, respond.
- Result and flags are registered and returned over a valid/ready response channel tagged with the requester id.
- Sits between the board-input decoder and the LED/seven-segment result path; it owns the only ALU instance.

---
 rtl/alu_arb_seq_pkg.sv | 26 ++
 rtl/alu_arb_seq_alu_core.sv | 54 +++++
 rtl/alu_arb_seq.sv | 143 ++++++++++++++
 tb/tb_alu_arb_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_seq_pkg.sv
// Shared definitions for the two-requester ALU sequencer: opcodes,
// controller state encoding and the flag bundle layout.
package alu_arb_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic cout;
        logic over;
        logic zero;
    } flags_t;

endpackage

// File: rtl/alu_arb_seq_alu_core.sv
// Purely combinational W-bit ALU; over/cout are meaningful only for add/sub.
module alu_core
    import alu_arb_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] f,
    output logic         zero,
    output logic         over,
    output logic         cout
);

    logic [W:0] sum;
    logic       lt;
    logic       eq;

    assign lt = ($signed(a) < $signed(b));
    assign eq = (a == b);

    always_comb begin
        sum  = '0;
        f    = '0;
        over = 1'b0;
        cout = 1'b0;
        case (op)
            OP_ADD: begin
                sum  = {1'b0, a} + {1'b0, b};
                f    = sum[W-1:0];
                cout = sum[W];
                over = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
            end
            OP_SUB: begin
                // cout=1 means no borrow, as in a+~b+1
                sum  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                f    = sum[W-1:0];
                cout = sum[W];
                over = (a[W-1] != b[W-1]) && (f[W-1] != a[W-1]);
            end
            OP_NOT:  f = ~a;
            OP_AND:  f = a & b;
            OP_OR:   f = a | b;
            OP_XOR:  f = a ^ b;
            OP_SLT:  f = {{(W-1){1'b0}}, lt};
            OP_EQ:   f = {{(W-1){1'b0}}, eq};
            default: f = '0;
        endcase
    end

    assign zero = (f == '0);

endmodule

// File: rtl/alu_arb_seq.sv
// Round-robin shares one ALU between two requesters; IDLE->EXEC->RESP sequencing,
// response valid two cycles after grant, held until rsp_ready.
module alu_arb_seq
    import alu_arb_seq_pkg::*;
#(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_f,
    output logic             rsp_zero,
    output logic             rsp_over,
    output logic             rsp_cout,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_t         state;
    state_t         state_nxt;
    logic           rr_last;
    logic           grant0;
    logic           grant1;
    logic [2:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           id_q;
    logic [W-1:0]   alu_f;
    flags_t         alu_flags;
    logic           rsp_done;

    alu_core #(.W(W)) u_alu (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .f    (alu_f),
        .zero (alu_flags.zero),
        .over (alu_flags.over),
        .cout (alu_flags.cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // rr_last=1 means req1 was granted last, so req0 wins the next tie.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    if (req0_valid && (!req1_valid || rr_last)) begin
                        grant0 = 1'b1;
                    end else if (req1_valid) begin
                        grant1 = 1'b1;
                    end
                end
                if (grant0 || grant1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);
    assign rsp_done   = (state == RESP) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
        end else if (grant0 || grant1) begin
            rr_last <= grant1;
            id_q    <= grant1;
            op_q    <= grant1 ? req1_op : req0_op;
            a_q     <= grant1 ? req1_a  : req0_a;
            b_q     <= grant1 ? req1_b  : req0_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_f     <= '0;
            rsp_zero  <= 1'b0;
            rsp_over  <= 1'b0;
            rsp_cout  <= 1'b0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_f     <= alu_f;
            rsp_zero  <= alu_flags.zero;
            rsp_over  <= alu_flags.over;
            rsp_cout  <= alu_flags.cout;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (rsp_done) begin
            if (!rsp_id && (cnt0 != {CNT_W{1'b1}})) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (rsp_id && (cnt1 != {CNT_W{1'b1}})) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_arb_seq.sv
// Directed bench for alu_arb_seq; a second instance with CNT_W=2 shares the
// stimulus so counter saturation is visible alongside the full-width counters.
module tb_alu_arb_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_ready;

    logic         req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [W-1:0] rsp_f;
    logic         rsp_zero, rsp_over, rsp_cout, busy;
    logic [7:0]   cnt0, cnt1;

    logic         s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id;
    logic [W-1:0] s_rsp_f;
    logic         s_rsp_zero, s_rsp_over, s_rsp_cout, s_busy;
    logic [1:0]   s_cnt0, s_cnt1;

    int n_assert = 0;
    int n_fail   = 0;

    // Captured response of the last op issued through run_op.
    logic         cap_valid, cap_id, cap_zero, cap_over, cap_cout;
    logic [W-1:0] cap_f;

    always #5 clk = ~clk;

    alu_arb_seq #(.W(W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_f(rsp_f), .rsp_zero(rsp_zero), .rsp_over(rsp_over), .rsp_cout(rsp_cout),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    alu_arb_seq #(.W(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_f(s_rsp_f), .rsp_zero(s_rsp_zero), .rsp_over(s_rsp_over), .rsp_cout(s_rsp_cout),
        .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one op from requester id with rsp_ready high, starting at the next
    // falling edge with the controller in IDLE; returns on the RESP cycle.
    task automatic run_op(input logic id, input logic [2:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        check("op_grant", id ? req1_ready : req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        cap_valid = rsp_valid;
        cap_id    = rsp_id;
        cap_f     = rsp_f;
        cap_zero  = rsp_zero;
        cap_over  = rsp_over;
        cap_cout  = rsp_cout;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;

        // Reset state, with a requester already valid during reset
        @(negedge clk);
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_f", rsp_f, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        req0_valid = 1'b0;
        rst = 1'b0;

        // add 7+1 -> 8, signed overflow, no carry
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'd7; req0_b = 4'd1;
        #1;
        check("add_ready0", req0_ready, 1);
        check("add_ready1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("add_exec_ready0", req0_ready, 0);
        check("add_exec_busy", busy, 1);
        check("add_exec_valid", rsp_valid, 0);
        @(negedge clk);
        check("add_valid", rsp_valid, 1);
        check("add_id", rsp_id, 0);
        check("add_f", rsp_f, 8);
        check("add_over", rsp_over, 1);
        check("add_cout", rsp_cout, 0);
        check("add_zero", rsp_zero, 0);
        @(negedge clk);
        check("add_cnt0", cnt0, 1);
        check("add_done_valid", rsp_valid, 0);
        check("add_done_busy", busy, 0);

        // Directed ALU vectors through requester 1: {cout,over,zero}
        run_op(1'b1, 3'b001, 4'd3, 4'd3);
        check("sub33_id", cap_id, 1);
        check("sub33_f", cap_f, 0);
        check("sub33_flags", {cap_cout, cap_over, cap_zero}, 3'b101);
        run_op(1'b1, 3'b110, 4'b1000, 4'b0001);
        check("slt_f", cap_f, 1);
        check("slt_flags", {cap_cout, cap_over, cap_zero}, 3'b000);
        run_op(1'b1, 3'b001, 4'd2, 4'd3);
        check("sub23_f", cap_f, 4'hF);
        check("sub23_flags", {cap_cout, cap_over, cap_zero}, 3'b000);
        run_op(1'b1, 3'b001, 4'h8, 4'h1);
        check("sub81_f", cap_f, 4'h7);
        check("sub81_flags", {cap_cout, cap_over, cap_zero}, 3'b110);
        run_op(1'b1, 3'b000, 4'hF, 4'h1);
        check("add_f1_f", cap_f, 4'h0);
        check("add_f1_flags", {cap_cout, cap_over, cap_zero}, 3'b101);
        run_op(1'b1, 3'b010, 4'h5, 4'h0);
        check("not_f", cap_f, 4'hA);
        run_op(1'b1, 3'b011, 4'hC, 4'hA);
        check("and_f", cap_f, 4'h8);
        run_op(1'b1, 3'b100, 4'hC, 4'hA);
        check("or_f", cap_f, 4'hE);
        run_op(1'b1, 3'b101, 4'h5, 4'h5);
        check("xor_f", cap_f, 4'h0);
        check("xor_flags", {cap_cout, cap_over, cap_zero}, 3'b001);
        run_op(1'b1, 3'b111, 4'h9, 4'h9);
        check("eq_f", cap_f, 4'h1);
        run_op(1'b1, 3'b110, 4'h1, 4'h8);
        check("slt_rev_f", cap_f, 4'h0);
        @(negedge clk);
        check("vec_cnt0", cnt0, 1);
        check("vec_cnt1", cnt1, 11);

        // Tie fairness: both valid continuously for four grants
        do_reset();
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'd1; req0_b = 4'd1;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 4'd2; req1_b = 4'd2;
        for (int g = 0; g < 4; g++) begin
            #1;
            check("tie_ready0", req0_ready, (g % 2 == 0) ? 1 : 0);
            check("tie_ready1", req1_ready, (g % 2 == 1) ? 1 : 0);
            @(negedge clk);
            @(negedge clk);
            check("tie_id", rsp_id, g % 2);
            check("tie_f", rsp_f, (g % 2 == 0) ? 2 : 4);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("tie_cnt0", cnt0, 2);
        check("tie_cnt1", cnt1, 2);

        // Backpressure: response held for 5 cycles, then req1 wins right after
        rsp_ready = 1'b0;
        run_op(1'b0, 3'b000, 4'd2, 4'd3);
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 4'd1; req1_b = 4'd1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_f", rsp_f, 5);
            check("bp_id", rsp_id, 0);
            check("bp_busy", busy, 1);
            check("bp_readies", {req0_ready, req1_ready}, 2'b00);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_readies", {req0_ready, req1_ready}, 2'b00);
        @(negedge clk);
        #1;
        check("bp_next_ready1", req1_ready, 1);
        check("bp_next_ready0", req0_ready, 0);
        check("bp_cnt0", cnt0, 3);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("bp_next_id", rsp_id, 1);
        check("bp_next_f", rsp_f, 2);

        // Reset in EXEC discards the op and restores the req0-first pointer
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'd4; req0_b = 4'd4;
        #1;
        check("mid_grant0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_valid", rsp_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_f", rsp_f, 0);
        check("mid_cnt", {cnt0, cnt1}, 16'h0000);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("mid_tie0", req0_ready, 1);
        check("mid_tie1", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("mid_rsp_id", rsp_id, 0);
        check("mid_rsp_f", rsp_f, 8);
        @(negedge clk);

        // Counter saturation on the 2-bit instance
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_op(1'b0, 3'b100, 4'd1, 4'd2);
        end
        @(negedge clk);
        check("sat_wide_cnt0", cnt0, 5);
        check("sat_cnt0", s_cnt0, 3);
        check("sat_cnt1", s_cnt1, 0);
        check("sat_f", s_rsp_f, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
